// File: rtl/parity_sched_pkg.sv
//------------------------------------------------------------------------------
// Module  : parity_sched_pkg
// Brief   : Shared types, defaults and helpers for the parity frame scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package parity_sched_pkg;

  localparam int c_N_REQ_DEFAULT  = 4;
  localparam int c_DATA_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Zero-extension leaves the XOR reduction unchanged, so one width serves all.
  function automatic logic f_even_parity(input logic [31:0] i_word);
    return ^i_word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick starting at i_ptr; pointer lives in parent.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_enable,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_any_grant
);

  int w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_id  = '0;
    o_any_grant = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % N_REQ;
      if (i_enable && !o_any_grant && i_req[w_idx]) begin
        o_any_grant    = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = ID_W'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/parity_frame_scheduler.sv
//------------------------------------------------------------------------------
// Module  : parity_frame_scheduler
// Brief   : Round-robin share of one LSB-first serial lane with trailing even-parity beat.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module parity_frame_scheduler
  import parity_sched_pkg::*;
#(
  parameter int N_REQ  = c_N_REQ_DEFAULT,
  parameter int DATA_W = c_DATA_W_DEFAULT,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_tx_bit,
  output logic                    o_tx_parity,
  output logic                    o_tx_last,
  output logic [ID_W-1:0]         o_grant_id,
  output logic                    o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [DATA_W-1:0] r_shreg;
  logic              r_par_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_tx_valid;
  logic              r_tx_bit;
  logic              r_tx_parity;
  logic              r_tx_last;
  logic [ID_W-1:0]   r_grant_id;
  logic              r_busy;

  logic              w_accept_slot;
  logic              w_arb_en;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_win_id;
  logic              w_any_grant;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_shift_next;
  logic [ID_W-1:0]   w_ptr_next;

  // The parity beat doubles as the next frame's accept slot, giving bubble-free frames.
  assign w_accept_slot = (r_state == ST_IDLE) || ((r_state == ST_PARITY) && i_tx_ready);
  assign w_arb_en      = w_accept_slot && !reset;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .i_enable    (w_arb_en),
    .o_grant     (w_grant),
    .o_grant_id  (w_win_id),
    .o_any_grant (w_any_grant)
  );

  always_comb begin
    w_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_word = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_shift_next = r_shreg >> 1;
  assign w_ptr_next   = (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_shreg     <= '0;
      r_par_acc   <= 1'b0;
      r_cnt       <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_bit    <= 1'b0;
      r_tx_parity <= 1'b0;
      r_tx_last   <= 1'b0;
      r_grant_id  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (i_tx_ready) begin
            r_shreg <= w_shift_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == c_LAST_BEAT) begin
              r_state     <= ST_PARITY;
              r_tx_bit    <= r_par_acc;
              r_tx_parity <= 1'b1;
              r_tx_last   <= 1'b1;
            end else begin
              r_tx_bit <= w_shift_next[0];
            end
          end
        end
        default: begin
          if (w_accept_slot) begin
            if (w_any_grant) begin
              r_state     <= ST_SHIFT;
              r_ptr       <= w_ptr_next;
              r_grant_id  <= w_win_id;
              r_shreg     <= w_word;
              r_par_acc   <= f_even_parity(32'(w_word));
              r_cnt       <= '0;
              r_tx_valid  <= 1'b1;
              r_tx_bit    <= w_word[0];
              r_tx_parity <= 1'b0;
              r_tx_last   <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_tx_valid  <= 1'b0;
              r_tx_bit    <= 1'b0;
              r_tx_parity <= 1'b0;
              r_tx_last   <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_req_ready = w_grant;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_bit    = r_tx_bit;
  assign o_tx_parity = r_tx_parity;
  assign o_tx_last   = r_tx_last;
  assign o_grant_id  = r_grant_id;
  assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: doc/parity_frame_scheduler.md
Name: parity_frame_scheduler

Overview:
Shares one serial even-parity framing lane between N_REQ parallel requesters. Each cycle it round-robin arbitrates among valid requesters and latches the granted DATA_W-bit word. It serializes the word LSB-first, then appends one even-parity beat, which is the XOR of the data bits so that total ones are even. It sits between the word-level producers and the serial transmit path, and gives back-to-back frames with no bubble.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 3, data bits per frame (>=1)
ID_W, $clog2(N_REQ), width of grant id (derived, not overridable)

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge
i_req_valid  input  N_REQ  per-requester word valid
i_req_data  input  N_REQ*DATA_W  requester k occupies bits [k*DATA_W +: DATA_W]
o_req_ready  output  N_REQ  one-hot accept pulse; word k transferred when valid[k]&ready[k]
o_tx_valid  output  1  serial beat valid
i_tx_ready  input  1  downstream accepts beat when o_tx_valid&i_tx_ready
o_tx_bit  output  1  serial beat value (data bit or parity bit)
o_tx_parity  output  1  high on the parity beat
o_tx_last  output  1  high on final beat of frame (same as the parity beat)
o_grant_id  output  ID_W  requester owning current frame
o_busy  output  1  high while a frame is in flight (SHIFT or PARITY)

Behaviour:
- Reset (sync): state=IDLE, all outputs 0, shift reg 0, parity acc 0, bit counter 0, RR pointer 0, so requester 0 has top priority first.
- States: IDLE, SHIFT, PARITY.
- Arbitration is round-robin. Search starts at ptr and goes ptr, ptr+1, ... mod N_REQ. The first valid requester wins.
- On a grant: ptr <= winner+1 (mod N_REQ). o_grant_id <= winner.
- "Accept slot" means either of: state==IDLE, or state==PARITY with i_tx_ready=1.
  - In an accept slot with any valid requester: o_req_ready[winner]=1 (combinational, this cycle only).
  - Next edge: load word, parity acc <= ^word, bit counter <= 0, state <= SHIFT.
- Accept slot with no valid requester: PARITY -> IDLE (when the beat is accepted); IDLE stays IDLE.
- o_req_ready is 0 outside accept slots, and 0 in any cycle where reset=1.
- SHIFT:
  - o_tx_valid=1, o_tx_bit=shreg[0], o_tx_parity=0, o_tx_last=0.
  - On i_tx_ready: shift right one bit and increment the counter.
  - After beat DATA_W-1 is accepted, state <= PARITY.
- PARITY: o_tx_valid=1, o_tx_bit=parity acc, o_tx_parity=1, o_tx_last=1.
- Backpressure: while i_tx_ready=0, every output and all internal state hold. Nothing is dropped or duplicated.
- Frame length is always DATA_W+1 accepted beats. Latency from request accept to first beat on o_tx_valid is 1 cycle.
- Back-to-back: a grant in the PARITY accept slot puts the next frame's bit 0 on the very next cycle. o_tx_valid never drops between frames.
- Requester protocol:
  - valid and data must stay stable until ready.
  - A deassertion before a grant is legal; the request is ignored.
  - Data is sampled only in the grant cycle.
- Simultaneous requests: strict RR order. No requester waits more than N_REQ-1 frames.
- o_busy=1 in SHIFT and PARITY, 0 in IDLE.
- Reset mid-frame: the frame is abandoned (no parity beat), the next cycle shows all outputs 0, and ptr returns to 0.
- Counter width is $clog2(DATA_W+1). Counter wrap-around is not reachable.

Decomposition:
- Package parity_sched_pkg holds:
  - state enum (IDLE, SHIFT, PARITY)
  - default N_REQ/DATA_W localparams
  - function for the even-parity reduction
- One sub-module, rr_arbiter (parameter N_REQ):
  - inputs: req vector, ptr, enable
  - outputs: one-hot grant, encoded id, any_grant
  - purely combinational; the pointer register lives in the parent.

Test Plan:
1. After reset, req0 valid data 3'b101 -> ready[0] pulse, grant_id 0; beats 1,0,1 then parity beat bit 0 with o_tx_parity=o_tx_last=1; then IDLE, o_busy 0.
2. req1 data 3'b100, then req2 data 3'b111 -> beats 0,0,1,P=1; then 1,1,1,P=1; 3'b000 frame gives P=0.
3. All four valid at once after reset, tx_ready tied 1 -> grants 0,1,2,3 in order. o_tx_valid stays high for 16 consecutive cycles; o_tx_last on cycles 4,8,12,16.
4. req0 and req2 held valid continuously -> grant sequence 0,2,0,2,... Each ready pulse is one-hot and coincides with an accept slot.
5. i_tx_ready low for 2 cycles on data beat 2 of 3'b110 -> o_tx_bit=1 held 3 cycles and o_tx_valid held. The frame finishes 2 cycles late; beat sequence 0,1,1,P=0 is unchanged.
6. reset pulsed during beat 2 while req3 is waiting -> the cycle after reset shows all outputs 0 and no parity beat is emitted. Then req3 is granted first, since it is the only valid requester and ptr=0.
